// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and clear-engine state type for the register file
package regfile_pkg;
    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    typedef enum logic {IDLE, CLEAR} clr_state_t;
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: walks registers 1..NREGS-1 one per cycle, zeroing each
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_idx_o
);
    clr_state_t    state_q;
    logic [AW-1:0] idx_q;
    logic          busy_q;
    logic          last;
    assign last      = idx_q == AW'(NREGS - 1);
    assign busy_o    = busy_q;
    assign clr_we_o  = busy_q;
    assign clr_idx_o = idx_q;
    // Start on a request from IDLE; stop after the last register, rewinding to 1 so register 0 is never touched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= AW'(1);
            busy_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (clr_req_i) begin
                state_q <= CLEAR;
                busy_q  <= 1'b1;
            end
        end else begin
            idx_q <= last ? AW'(1) : idx_q + AW'(1);
            if (last) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write bypass, debug observe port and clear engine
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NWR-1:0]           we,
    input  logic [NWR-1:0][AW-1:0]   w_reg,
    input  logic [NWR-1:0][XLEN-1:0] w_data,
    input  logic [NRD-1:0][AW-1:0]   r_reg,
    output logic [NRD-1:0][XLEN-1:0] r_data,
    input  logic [AW-1:0]            dbg_addr,
    output logic [XLEN-1:0]          dbg_data,
    input  logic                     clr_req,
    output logic                     busy
);
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] dbg_q, dbg_d;
    logic [NWR-1:0]  wr_en;
    logic            clr_we;
    logic [AW-1:0]   clr_idx;

    regfile_clear_seq #(.NREGS(NREGS)) u_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req_i (clr_req),
        .busy_o    (busy),
        .clr_we_o  (clr_we),
        .clr_idx_o (clr_idx)
    );

    // Stored value of a register with this cycle's accepted writes forwarded; later ports override earlier ones
    function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = regs_q[a];
        for (int i = 0; i < NWR; i++)
            if (wr_en[i] && w_reg[i] == a) v = w_data[i];
        return (a == '0) ? '0 : v;
    endfunction

    // Writes are accepted only outside a clear and never to register 0
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NWR; i++) wr_en[i] = we[i] && w_reg[i] != '0 && !busy;
    end

    // Combinational read ports and next debug value, both through the bypass path
    always_comb begin
        r_data = '0;
        for (int j = 0; j < NRD; j++) r_data[j] = fwd(r_reg[j]);
        dbg_d = fwd(dbg_addr);
    end

    // Storage: clear engine owns the array while busy, otherwise ports commit in index order so the highest wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
        end else if (clr_we) begin
            regs_q[clr_idx] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++)
                if (wr_en[i]) regs_q[w_reg[i]] <= w_data[i];
        end
    end

    // Debug observe register, refreshed every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dbg_q <= '0;
        else        dbg_q <= dbg_d;
    end

    assign dbg_data = dbg_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp with two write ports
module tb_regfile_mp;
    localparam int XLEN = 64, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NWR-1:0]           we = '0;
    logic [NWR-1:0][AW-1:0]   w_reg = '0;
    logic [NWR-1:0][XLEN-1:0] w_data = '0;
    logic [NRD-1:0][AW-1:0]   r_reg = '0;
    logic [NRD-1:0][XLEN-1:0] r_data;
    logic [AW-1:0]            dbg_addr = '0;
    logic [XLEN-1:0]          dbg_data;
    logic                     clr_req = 1'b0;
    logic                     busy;

    logic [XLEN-1:0] mdl [NREGS];
    logic            m_busy;
    int              m_idx;
    logic [XLEN-1:0] dbg_exp [$];
    int              n_vec = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .w_reg    (w_reg),
        .w_data   (w_data),
        .r_reg    (r_reg),
        .r_data   (r_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = mdl[a];
        if (!m_busy)
            for (int i = 0; i < NWR; i++)
                if (we[i] && w_reg[i] == a) v = w_data[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREGS; k++) mdl[k] = '0;
        m_busy = 1'b0;
        m_idx  = 1;
        dbg_exp.delete();
        dbg_exp.push_back('0);
    endtask

    task automatic set_w(input logic [1:0] e, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                         input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        we = e;
        w_reg[0] = a0; w_data[0] = d0;
        w_reg[1] = a1; w_data[1] = d1;
    endtask

    // One clock: check reads/busy/debug at negedge, queue next debug value, then advance the model at posedge
    task automatic cyc();
        @(negedge clk);
        for (int j = 0; j < NRD; j++)
            check($sformatf("rd%0d[r%0d]", j, r_reg[j]), r_data[j], exp_rd(r_reg[j]));
        check("busy", XLEN'(busy), XLEN'(m_busy));
        if (dbg_exp.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL dbg: scoreboard empty, got %h", dbg_data);
        end else begin
            check($sformatf("dbg[r%0d]", dbg_addr), dbg_data, dbg_exp.pop_front());
        end
        dbg_exp.push_back(exp_rd(dbg_addr));
        @(posedge clk);
        if (m_busy) begin
            mdl[m_idx] = '0;
            if (m_idx == NREGS - 1) begin m_busy = 1'b0; m_idx = 1; end
            else m_idx++;
        end else begin
            for (int i = 0; i < NWR; i++)
                if (we[i] && w_reg[i] != 0) mdl[w_reg[i]] = w_data[i];
            if (clr_req) m_busy = 1'b1;
        end
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // reset contents, all addresses on both ports and debug
        for (int a = 0; a < NREGS; a++) begin
            r_reg[0] = AW'(a); r_reg[1] = AW'(NREGS - 1 - a); dbg_addr = AW'(a);
            cyc();
        end
        // single write bypass then stored value
        set_w(2'b01, 5, 64'hDEAD_BEEF, 0, 0); r_reg[0] = 5; r_reg[1] = 6; dbg_addr = 5;
        cyc();
        set_w(2'b00, 0, 0, 0, 0);
        cyc();
        cyc();
        // collision: port 1 wins
        set_w(2'b11, 7, 64'h11, 7, 64'h22); r_reg[0] = 7; r_reg[1] = 5; dbg_addr = 7;
        cyc();
        set_w(2'b00, 0, 0, 0, 0);
        cyc();
        cyc();
        // write to register 0 dropped
        set_w(2'b11, 0, 64'h55, 0, 64'h66); r_reg[0] = 0; r_reg[1] = 0; dbg_addr = 0;
        cyc();
        set_w(2'b00, 0, 0, 0, 0);
        cyc();
        cyc();
        // fill with index, then clear with a same-cycle write
        for (int a = 1; a < NREGS; a++) begin
            set_w(2'b01, AW'(a), XLEN'(a), 0, 0); r_reg[0] = AW'(a); dbg_addr = AW'(a);
            cyc();
        end
        set_w(2'b01, 2, 64'hABC, 0, 0); clr_req = 1'b1; r_reg[0] = 2; dbg_addr = 2;
        cyc();
        clr_req = 1'b0; set_w(2'b00, 0, 0, 0, 0); r_reg[0] = 10; r_reg[1] = 20;
        for (int c = 0; c < NREGS - 1; c++) begin
            set_w(c == 5 ? 2'b01 : 2'b00, 3, 64'h333, 0, 0);
            clr_req = (c == 8);
            dbg_addr = AW'(c % NREGS);
            cyc();
        end
        set_w(2'b00, 0, 0, 0, 0); clr_req = 1'b0;
        for (int a = 0; a < NREGS; a++) begin
            r_reg[0] = AW'(a); r_reg[1] = 3; dbg_addr = AW'(a);
            cyc();
        end
        // refill, start a clear, reset asynchronously partway through
        for (int a = 1; a < NREGS; a += 2) begin
            set_w(2'b11, AW'(a), 64'h100 + XLEN'(a), AW'((a + 1) % NREGS), 64'h100 + XLEN'(a + 1));
            r_reg[0] = AW'(a); dbg_addr = AW'(a);
            cyc();
        end
        set_w(2'b00, 0, 0, 0, 0); clr_req = 1'b1; r_reg[0] = 25; r_reg[1] = 30;
        cyc();
        clr_req = 1'b0;
        repeat (11) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("rst busy", XLEN'(busy), '0);
        check("rst r25", r_data[0], '0);
        check("rst r30", r_data[1], '0);
        check("rst dbg", dbg_data, '0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_w(2'b01, 4, 64'h44, 0, 0); r_reg[0] = 4; r_reg[1] = 25; dbg_addr = 4;
        cyc();
        set_w(2'b00, 0, 0, 0, 0);
        cyc();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
